deserializer: RTL and testbench

Serial-to-parallel converter that sits directly downstream of the serializer stage. It collects an MSB-first serial bit stream, qualified by a valid strobe, and reassembles it into 16-bit words together with a valid-bit count in the same `data_mod` encoding the serializer accepts. A word is emitted either when 16 bits have arrived or when the valid strobe drops after a partial burst. Bursts too short to be legal serializer output (1–2 bits) are discarded and flagged.

---
 rtl/deserializer.sv | 104 ++++++++++
 tb/tb_deserializer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// deserializer: collects an MSB-first serial bit stream qualified by a valid
// strobe and reassembles it into WIDTH-bit words plus a valid-bit count.
// A word is emitted after WIDTH bits, or when the valid strobe drops after a
// partial burst of 3 or more bits. Bursts of 1-2 bits are dropped and flagged.
//
// Ports:
//   clk_i             clock, rising edge
//   srst_i            synchronous reset, active-high
//   ser_data_i        serial data bit, MSB first
//   ser_data_val_i    ser_data_i valid this cycle
//   deser_data_o      reassembled word, first bit at [WIDTH-1], unused low bits 0
//   deser_data_mod_o  number of valid bits, 0 means WIDTH
//   deser_data_val_o  one-cycle strobe qualifying data/mod
//   runt_o            one-cycle strobe, a 1- or 2-bit burst was dropped
//   busy_o            partial word in progress (bit count != 0)
module deserializer #(
    parameter int WIDTH = 16,
    localparam int MOD_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             ser_data_i,
    input  logic             ser_data_val_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic [MOD_W-1:0] deser_data_mod_o,
    output logic             deser_data_val_o,
    output logic             runt_o,
    output logic             busy_o
);

    logic [WIDTH-1:0] sr_q,   sr_d;
    logic [MOD_W-1:0] cnt_q,  cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [MOD_W-1:0] mod_q,  mod_d;
    logic             val_q,  val_d;
    logic             runt_q, runt_d;
    logic             busy_q, busy_d;
    logic [MOD_W-1:0] idx;

    // Bit position for the incoming bit: first bit lands in the MSB.
    assign idx = MOD_W'(WIDTH - 1) - cnt_q;

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        mod_d  = mod_q;
        val_d  = 1'b0;
        runt_d = 1'b0;

        if (ser_data_val_i) begin
            if (cnt_q == MOD_W'(WIDTH - 1)) begin
                // Last bit goes straight to the output alongside the stored bits.
                data_d = {sr_q[WIDTH-1:1], ser_data_i};
                mod_d  = '0;
                val_d  = 1'b1;
                cnt_d  = '0;
                sr_d   = '0;
            end else begin
                sr_d[idx] = ser_data_i;
                cnt_d     = cnt_q + MOD_W'(1);
            end
        end else if (cnt_q != '0) begin
            if (cnt_q >= MOD_W'(3)) begin
                data_d = sr_q;
                mod_d  = cnt_q;
                val_d  = 1'b1;
            end else begin
                runt_d = 1'b1;
            end
            cnt_d = '0;
            sr_d  = '0;
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            mod_q  <= '0;
            val_q  <= 1'b0;
            runt_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            mod_q  <= mod_d;
            val_q  <= val_d;
            runt_q <= runt_d;
            busy_q <= busy_d;
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_mod_o = mod_q;
    assign deser_data_val_o = val_q;
    assign runt_o           = runt_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: table-driven vectors, hand-written corner sequences and a
// randomized burst stream compared against a behavioural reference model.
module tb_deserializer;

    logic        clk;
    logic        srst;
    logic        ser_data;
    logic        ser_val;
    logic [15:0] data_o;
    logic [3:0]  mod_o;
    logic        val_o;
    logic        runt_o;
    logic        busy_o;

    deserializer #(.WIDTH(16)) dut (
        .clk_i            (clk),
        .srst_i           (srst),
        .ser_data_i       (ser_data),
        .ser_data_val_i   (ser_val),
        .deser_data_o     (data_o),
        .deser_data_mod_o (mod_o),
        .deser_data_val_o (val_o),
        .runt_o           (runt_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          runt;
        logic [15:0] data;
        logic [3:0]  mod;
        int          cyc;
    } ev_t;

    ev_t obs[$];
    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  both_hi = 0;

    // Observed strobe events, sampled away from the active edge.
    always @(negedge clk) begin
        ev_t e;
        if (val_o && runt_o) both_hi++;
        if (val_o || runt_o) begin
            e.runt = runt_o;
            e.data = data_o;
            e.mod  = mod_o;
            e.cyc  = cyc;
            obs.push_back(e);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives n bits of value (MSB of the n-bit field first) on consecutive
    // cycles, leaving val high; returns the cycle of the edge that sampled
    // the last bit.
    task automatic send_bits(input logic [15:0] value, input int n, output int last_cyc);
        for (int i = n - 1; i >= 0; i--) begin
            ser_data = value[i];
            ser_val  = 1'b1;
            @(posedge clk); #1;
        end
        last_cyc = cyc;
    endtask

    task automatic idle(input int k);
        ser_val  = 1'b0;
        ser_data = $urandom_range(0, 1);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Reference model: a burst of n bits is left-aligned into the word.
    function automatic ev_t model(input logic [15:0] value, input int n);
        ev_t e;
        logic [31:0] wide;
        e.cyc = 0;
        if (n < 3) begin
            e.runt = 1'b1;
            e.data = '0;
            e.mod  = '0;
        end else begin
            wide   = 32'(value) << (16 - n);
            e.runt = 1'b0;
            e.data = wide[15:0];
            e.mod  = (n == 16) ? 4'd0 : 4'(n);
        end
        return e;
    endfunction

    task automatic check_events(input string tag);
        int n;
        check({tag, "_count"}, obs.size(), exp_q.size());
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_runt"}, 32'(obs[i].runt), 32'(exp_q[i].runt));
            if (!exp_q[i].runt) begin
                check({tag, "_data"}, 32'(obs[i].data), 32'(exp_q[i].data));
                check({tag, "_mod"},  32'(obs[i].mod),  32'(exp_q[i].mod));
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [15:0] value;
        int          n;
        logic [15:0] exp_data;
        logic [3:0]  exp_mod;
        bit          exp_runt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   l1, l2, lst;
        logic [15:0] last_data;
        logic [15:0] w;
        int   n;
        ev_t  e;

        vecs[0] = '{16'hDAAC, 16, 16'hDAAC, 4'd0,  1'b0};
        vecs[1] = '{16'h001F, 5,  16'hF800, 4'd5,  1'b0};
        vecs[2] = '{16'h0002, 2,  16'h0000, 4'd0,  1'b1};
        vecs[3] = '{16'h0005, 3,  16'hA000, 4'd3,  1'b0};
        vecs[4] = '{16'h0001, 1,  16'h0000, 4'd0,  1'b1};
        vecs[5] = '{16'h7FFF, 15, 16'hFFFE, 4'd15, 1'b0};
        vecs[6] = '{16'h0081, 8,  16'h8100, 4'd8,  1'b0};

        srst = 1'b1; ser_val = 1'b0; ser_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;
        check("rst_data", 32'(data_o), 0);
        check("rst_mod",  32'(mod_o),  0);
        check("rst_val",  32'(val_o),  0);
        check("rst_runt", 32'(runt_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        obs.delete();

        // Table-driven vectors.
        last_data = '0;
        for (int i = 0; i < 7; i++) begin
            send_bits(vecs[i].value, vecs[i].n, lst);
            check("vec_busy_during", 32'(busy_o), (vecs[i].n == 16) ? 0 : 1);
            idle(3);
            check("vec_busy_after", 32'(busy_o), 0);
            e.runt = vecs[i].exp_runt;
            e.data = vecs[i].exp_data;
            e.mod  = vecs[i].exp_mod;
            e.cyc  = 0;
            exp_q.push_back(e);
            if (vecs[i].exp_runt)
                check("vec_runt_holds_data", 32'(data_o), 32'(last_data));
            else
                last_data = vecs[i].exp_data;
            check_events("vec");
        end

        // Full-word latency and back-to-back spacing.
        send_bits(16'hA5A5, 16, l1);
        send_bits(16'h0FF0, 16, l2);
        idle(4);
        check("b2b_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check("b2b_latency", obs[0].cyc, l1);
            check("b2b_spacing", obs[1].cyc - obs[0].cyc, 16);
            check("b2b_data0", 32'(obs[0].data), 32'hA5A5);
            check("b2b_data1", 32'(obs[1].data), 32'h0FF0);
            check("b2b_mod0",  32'(obs[0].mod), 0);
            check("b2b_mod1",  32'(obs[1].mod), 0);
        end
        obs.delete();

        // Partial-word latency: strobe in the cycle after val falls.
        send_bits(16'h001F, 5, lst);
        idle(1);
        check("part_val", 32'(val_o), 1);
        check("part_busy", 32'(busy_o), 0);
        idle(1);
        check("part_val_one_cycle", 32'(val_o), 0);
        check("part_lat_count", obs.size(), 1);
        if (obs.size() == 1) check("part_latency", obs[0].cyc, lst + 1);
        obs.delete();

        // Reset mid-word discards the partial burst.
        send_bits(16'h0055, 7, lst);
        ser_val = 1'b0; srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_data", 32'(data_o), 0);
        send_bits(16'h1234, 16, lst);
        idle(3);
        e = model(16'h1234, 16);
        exp_q.push_back(e);
        check_events("mid_rst");

        // Randomized bursts with idle gaps against the reference model.
        for (int b = 0; b < 40; b++) begin
            n = $urandom_range(3, 16);
            w = 16'($urandom);
            if (n < 16) w = w & 16'((32'd1 << n) - 1);
            exp_q.push_back(model(w, n));
            send_bits(w, n, lst);
            idle($urandom_range(1, 5));
        end
        idle(3);
        check_events("rand");

        check("strobes_exclusive", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
